mem_arbiter: RTL

- Shares the single-port 8-bit program/data RAM between two requesters: the CPU memory port and a DMA/IO engine.
- Sequences each RAM access (address phase, read wait, completion) with a req/gnt/done handshake.
- Arbitrates round-robin when both requesters contend.
- Sits between the requesters and the RAM macro, replacing direct CPU-to-RAM wiring.

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/mem_arbiter_if.sv | 24 ++
 rtl/mem_arbiter_rr_arb2.sv | 32 +++
 rtl/mem_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter shared types.
// FSM states and owner encodings.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } arb_state_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DMA = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side RAM access port.
// req/gnt/done handshake plus data.
interface mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              done;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, done, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, done, rdata
  );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker.
// Holds the last grantee; a tie goes to the other one.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic       winner
);
  import mem_arb_pkg::*;

  logic last_q;
  logic last_d;

  // Pick the winner; only a tie consults the pointer.
  always_comb begin
    winner = ~last_q;
    unique case (1'b1)
      (req == 2'b01): winner = OWNER_CPU;
      (req == 2'b10): winner = OWNER_DMA;
      default:        winner = ~last_q;
    endcase
    last_d = update ? winner : last_q;
  end

  // Pointer starts at DMA so the CPU wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= OWNER_DMA;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// CPU/DMA arbiter for the shared RAM.
// Sequences each access: ACCESS, optional WAIT, DONE.
module mem_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  mem_arbiter_if.slave      cpu,
  mem_arbiter_if.slave      dma,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              owner
);
  import mem_arb_pkg::*;

  localparam int CNT_W =
    (RAM_LAT > 0) ? $clog2(RAM_LAT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((RAM_LAT > 0) ? RAM_LAT - 1 : 0);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              ram_we_q, ram_we_d;
  logic              ram_re_q, ram_re_d;
  logic              busy_q, busy_d;
  logic              cpu_gnt_q, cpu_gnt_d;
  logic              dma_gnt_q, dma_gnt_d;
  logic              cpu_done_q, cpu_done_d;
  logic              dma_done_q, dma_done_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              win;
  logic              upd;
  logic              capture;
  logic              active;

  assign upd = (state_q == IDLE) && (cpu.req || dma.req);

  rr_arb2 u_rr (
    .clk    (clk),
    .rst_n  (reset),
    .req    ({dma.req, cpu.req}),
    .update (upd),
    .winner (win)
  );

  // Next state plus next registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    owner_d     = owner_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    capture     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (upd) begin
          state_d = ACCESS;
          owner_d = win;
          if (win == OWNER_DMA) begin
            we_d        = dma.we;
            ram_addr_d  = dma.addr;
            ram_wdata_d = dma.wdata;
          end else begin
            we_d        = cpu.we;
            ram_addr_d  = cpu.addr;
            ram_wdata_d = cpu.wdata;
          end
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = DONE;
        end else if (RAM_LAT == 0) begin
          capture = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          capture = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (capture) begin
      if (owner_q == OWNER_DMA) dma_rdata_d = ram_rdata;
      else                      cpu_rdata_d = ram_rdata;
    end
    active = (state_d == ACCESS) || (state_d == WAIT);
    if (!active) ram_wdata_d = '0;
    busy_d     = (state_d != IDLE);
    cpu_gnt_d  = busy_d && (owner_d == OWNER_CPU);
    dma_gnt_d  = busy_d && (owner_d == OWNER_DMA);
    cpu_done_d = (state_d == DONE) && (owner_d == OWNER_CPU);
    dma_done_d = (state_d == DONE) && (owner_d == OWNER_DMA);
    ram_we_d   = (state_d == ACCESS) && we_d;
    ram_re_d   = (state_d == ACCESS) && !we_d;
  end

  // FSM state and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      owner_q     <= OWNER_CPU;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      ram_re_q    <= 1'b0;
      busy_q      <= 1'b0;
      cpu_gnt_q   <= 1'b0;
      dma_gnt_q   <= 1'b0;
      cpu_done_q  <= 1'b0;
      dma_done_q  <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      owner_q     <= owner_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      ram_re_q    <= ram_re_d;
      busy_q      <= busy_d;
      cpu_gnt_q   <= cpu_gnt_d;
      dma_gnt_q   <= dma_gnt_d;
      cpu_done_q  <= cpu_done_d;
      dma_done_q  <= dma_done_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_we    = ram_we_q;
  assign ram_re    = ram_re_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
  assign cpu.gnt   = cpu_gnt_q;
  assign cpu.done  = cpu_done_q;
  assign cpu.rdata = cpu_rdata_q;
  assign dma.gnt   = dma_gnt_q;
  assign dma.done  = dma_done_q;
  assign dma.rdata = dma_rdata_q;

endmodule
